// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: FSM encoding, default
// parameter values and a small sizing helper.
package reset_sequencer_pkg;

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STAGE     = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_LOCK_FILTER = 4;
  localparam int DEF_STAGE_GAP   = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Status/reset bundle between a clock-source monitor and the reset sequencer.
interface reset_sequencer_if
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
);

  // lock_in is a level held by the source for as long as the clock is good;
  // soft_reset_req is a one-cycle pulse with no acknowledge. reset_out and
  // seq_done are registered levels from the sequencer, valid every cycle.
  logic                  lock_in;
  logic                  soft_reset_req;
  logic [NUM_STAGES-1:0] reset_out;
  logic                  seq_done;

  modport master (
    output lock_in,
    output soft_reset_req,
    input  reset_out,
    input  seq_done
  );

  modport slave (
    input  lock_in,
    input  soft_reset_req,
    output reset_out,
    output seq_done
  );

endinterface

// File: rtl/reset_sequencer_counter.sv
// Loadable down counter that sticks at zero; tc flags the last counted cycle
// (count == 1) so the owner can act on the edge the count expires.
module sat_down_counter
  import reset_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all resets, filter the clock lock, then release
// reset_out bits one by one in ascending order with a fixed gap.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic               clk_sync,
  input  logic               reset_sync,
  reset_sequencer_if.slave   bus,
  output logic [1:0]         fsm_state
);

  localparam int CNT_W = $clog2(max3(HOLD_CYCLES, LOCK_FILTER, STAGE_GAP) + 1);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_GAP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic [1:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic [NUM_STAGES-1:0] stage_mask;
  logic                  done_q, done_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  cnt_load;
  logic                  cnt_dec;
  logic [CNT_W-1:0]      cnt_val;
  logic [CNT_W-1:0]      cnt_count;
  logic                  cnt_tc;
  logic                  cnt_zero;
  logic                  reseq;

  // One counter serves hold, lock filter and stage gap; only one is live at a time.
  sat_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk_sync),
    .rst      (reset_sync),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .count    (cnt_count),
    .tc       (cnt_tc)
  );

  assign cnt_zero   = (cnt_count == '0);
  assign stage_mask = NUM_STAGES'(1) << idx_q;

  // Lock loss only matters once staging has begun; a soft request always counts.
  assign reseq = bus.soft_reset_req |
                 (~bus.lock_in & ((state_q == ST_STAGE) | (state_q == ST_DONE)));

  always_comb begin
    state_d   = state_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    idx_d     = idx_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;

    if (reseq) begin
      state_d   = ST_HOLD;
      rst_out_d = '1;
      done_d    = 1'b0;
      idx_d     = '0;
      cnt_load  = 1'b1;
      cnt_val   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // A cleared counter means HOLD was just entered: arm the hold count.
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
          end else if (cnt_tc) begin
            state_d  = ST_WAIT_LOCK;
            cnt_load = 1'b1;
            cnt_val  = LOCK_LD;
          end else begin
            cnt_dec = 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (!bus.lock_in) begin
            cnt_load = 1'b1;
            cnt_val  = LOCK_LD;
          end else if (cnt_tc) begin
            state_d  = ST_STAGE;
            cnt_load = 1'b1;
            cnt_val  = GAP_LD;
          end else begin
            cnt_dec = 1'b1;
          end
        end

        ST_STAGE: begin
          if (cnt_tc) begin
            rst_out_d = rst_out_q & ~stage_mask;
            cnt_load  = 1'b1;
            cnt_val   = GAP_LD;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d   = ST_HOLD;
          rst_out_d = '1;
          done_d    = 1'b0;
          idx_d     = '0;
          cnt_load  = 1'b1;
          cnt_val   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sync) begin
    if (reset_sync) begin
      state_q   <= ST_HOLD;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.reset_out = rst_out_q;
  assign bus.seq_done  = done_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a 1/1/1/1
// instance driven by the same stimulus, each checked against a timestamp model.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(3)) bus0();
  reset_sequencer_if #(.NUM_STAGES(1)) bus1();
  logic [1:0] st0, st1;

  reset_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(16), .LOCK_FILTER(4), .STAGE_GAP(8)
  ) dut0 (
    .clk_sync(clk), .reset_sync(rst), .bus(bus0), .fsm_state(st0)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .HOLD_CYCLES(1), .LOCK_FILTER(1), .STAGE_GAP(1)
  ) dut1 (
    .clk_sync(clk), .reset_sync(rst), .bus(bus1), .fsm_state(st1)
  );

  // ---------------- reference model ----------------
  // Per instance: edge of the last reset/re-sequence, current run of lock-high
  // samples, and the edge at which the filter was satisfied (-1 if not yet).
  int p_ns[2];
  int p_h[2];
  int p_l[2];
  int p_g[2];
  int t_seq[2];
  int run[2];
  int ok_at[2];
  int cyc;

  int n_checks;
  int n_fail;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  function automatic int released(input int d, input int n);
    int r;
    if (ok_at[d] < 0) return 0;
    r = (n - ok_at[d]) / p_g[d];
    return (r > p_ns[d]) ? p_ns[d] : r;
  endfunction

  task automatic model_step(input int d, input bit r, input bit s, input bit l);
    bit staging;
    staging = (ok_at[d] >= 0);
    if (r || s || (staging && !l)) begin
      t_seq[d] = cyc;
      run[d]   = 0;
      ok_at[d] = -1;
    end else if (!staging && (cyc > t_seq[d] + p_h[d] + 1)) begin
      // Lock is only filtered once the hold period has fully elapsed.
      run[d] = l ? run[d] + 1 : 0;
      if (run[d] >= p_l[d]) ok_at[d] = cyc;
    end
  endtask

  function automatic logic [8:0] model_exp(input int d);
    int rel;
    int mask;
    int outv;
    rel  = released(d, cyc);
    mask = (1 << p_ns[d]) - 1;
    outv = (mask << rel) & mask;
    return {(rel == p_ns[d]), 8'(outv)};
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit s, input bit l);
    logic [8:0] e0;
    logic [8:0] e1;
    rst                 = r;
    bus0.soft_reset_req = s;
    bus1.soft_reset_req = s;
    bus0.lock_in        = l;
    bus1.lock_in        = l;
    @(posedge clk);
    cyc++;
    model_step(0, r, s, l);
    model_step(1, r, s, l);
    exp_q0.push_back(model_exp(0));
    exp_q1.push_back(model_exp(1));
    #1;
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    check_eq("reset_out0", 32'(bus0.reset_out), 32'(e0[2:0]));
    check_eq("seq_done0",  32'(bus0.seq_done),  32'(e0[8]));
    check_eq("in_done0",   32'(st0 == ST_DONE), 32'(e0[8]));
    check_eq("reset_out1", 32'(bus1.reset_out), 32'(e1[0]));
    check_eq("seq_done1",  32'(bus1.seq_done),  32'(e1[8]));
    check_eq("in_done1",   32'(st1 == ST_DONE), 32'(e1[8]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit r;
    bit s;
    bit l;
    p_ns = '{3, 1};
    p_h  = '{16, 1};
    p_l  = '{4, 1};
    p_g  = '{8, 1};
    t_seq = '{0, 0};
    run   = '{0, 0};
    ok_at = '{-1, -1};
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    bus0.soft_reset_req = 1'b0;
    bus1.soft_reset_req = 1'b0;
    bus0.lock_in = 1'b1;
    bus1.lock_in = 1'b1;
    @(negedge clk);

    // Power-on: reset 5 cycles with lock high, then full sequence.
    repeat (5) step(1'b1, 1'b0, 1'b1);
    check_eq("por_out0",  32'(bus0.reset_out), 32'h7);
    check_eq("por_done0", 32'(bus0.seq_done), 32'h0);
    for (int i = 0; i <= 50; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (i == 2)  check_eq("min_pre1",   32'(bus1.reset_out), 32'h1);
      if (i == 3)  check_eq("min_rel1",   32'(bus1.reset_out), 32'h0);
      if (i == 3)  check_eq("min_done1",  32'(bus1.seq_done),  32'h1);
      if (i == 27) check_eq("seq_c27",    32'(bus0.reset_out), 32'h7);
      if (i == 28) check_eq("seq_c28",    32'(bus0.reset_out), 32'h6);
      if (i == 36) check_eq("seq_c36",    32'(bus0.reset_out), 32'h4);
      if (i == 43) check_eq("seq_c43",    32'(bus0.seq_done),  32'h0);
      if (i == 44) check_eq("seq_c44",    32'(bus0.reset_out), 32'h0);
      if (i == 44) check_eq("seq_done44", 32'(bus0.seq_done),  32'h1);
    end

    // Lock loss for one cycle in DONE, then a full re-run.
    step(1'b0, 1'b0, 1'b0);
    check_eq("lockloss_out", 32'(bus0.reset_out), 32'h7);
    check_eq("lockloss_done", 32'(bus0.seq_done), 32'h0);
    repeat (50) step(1'b0, 1'b0, 1'b1);

    // Chattering lock in WAIT_LOCK never satisfies the filter, then steady lock.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i <= 38; i++) step(1'b0, 1'b0, (i % 3) != 2);
    for (int j = 0; j <= 20; j++) begin
      step(1'b0, 1'b0, 1'b1);
      if (j == 10) check_eq("filt_c10", 32'(bus0.reset_out), 32'h7);
      if (j == 11) check_eq("filt_c11", 32'(bus0.reset_out), 32'h6);
    end
    repeat (20) step(1'b0, 1'b0, 1'b1);

    // Soft request right after bit 0 releases.
    repeat (2) step(1'b1, 1'b0, 1'b1);
    n = 0;
    while (bus0.reset_out[0] && n < 100) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    check_eq("wait_rel0", 32'(n < 100), 32'h1);
    step(1'b0, 1'b1, 1'b1);
    check_eq("soft_out", 32'(bus0.reset_out), 32'h7);
    repeat (50) step(1'b0, 1'b0, 1'b1);

    // Reset together with soft request and lock loss.
    repeat (30) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check_eq("combo_out",  32'(bus0.reset_out), 32'h7);
    check_eq("combo_done", 32'(bus0.seq_done),  32'h0);
    check_eq("combo_st",   32'(st0), 32'(ST_HOLD));
    repeat (50) step(1'b0, 1'b0, 1'b1);

    // Random traffic: rare resets/requests, occasional lock drops.
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 149) == 0);
      l = ($urandom_range(0, 59) != 0);
      step(r, s, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of staged reset outputs, legal range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles all outputs stay asserted after any reset or re-sequence, >=1.
REQ-003 SHALL have parameter LOCK_FILTER, default 4: consecutive cycles lock_in must be high before staging starts, >=1.
REQ-004 SHALL have parameter STAGE_GAP, default 8: cycles between successive stage releases, >=1.
REQ-005 SHALL have port clk_sync  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_sync  input  1  synchronous, active-high reset; this polarity and synchronicity are fixed.
REQ-007 SHALL have port lock_in  input  1  clock-source lock/ready status, synchronous to clk_sync.
REQ-008 SHALL have port soft_reset_req  input  1  single-cycle request to re-run the sequence.
REQ-009 SHALL have port reset_out  output  NUM_STAGES  per-stage active-high reset; bit 0 releases first.
REQ-010 SHALL have port seq_done  output  1  high only while every reset_out bit is deasserted.

Function
REQ-011 SHALL implement FSM states HOLD, WAIT_LOCK, STAGE, DONE, all outputs registered.
REQ-012 HOLD SHALL keep reset_out all-ones for exactly HOLD_CYCLES cycles, then enter WAIT_LOCK regardless of lock_in.
REQ-013 WAIT_LOCK SHALL count consecutive lock_in-high cycles; a low lock_in SHALL clear the count; LOCK_FILTER consecutive highs SHALL enter STAGE.
REQ-014 STAGE SHALL clear reset_out[k] STAGE_GAP cycles after entering STAGE (k=0) or after releasing bit k-1 (k>0), releasing bits strictly in ascending order, one per release event.
REQ-015 Releasing bit NUM_STAGES-1 SHALL enter DONE and assert seq_done on the same cycle that bit clears.
REQ-016 With lock_in held high, bit k SHALL clear HOLD_CYCLES+LOCK_FILTER+(k+1)*STAGE_GAP cycles after the first edge with reset_sync low.
REQ-017 lock_in low during STAGE or DONE SHALL reassert all reset_out bits, clear seq_done on the next edge, and enter HOLD with a fresh HOLD_CYCLES count.
REQ-018 soft_reset_req high in any state SHALL have the same effect as REQ-017, including in HOLD, where it SHALL restart the HOLD count.
REQ-019 Simultaneous lock loss and soft_reset_req SHALL be treated as one re-sequence event.
REQ-020 Once asserted by REQ-017/018, a reset_out bit SHALL never clear before a complete new HOLD, WAIT_LOCK, and STAGE pass.
REQ-021 Counters SHALL be sized $clog2(max(HOLD_CYCLES,LOCK_FILTER,STAGE_GAP)+1) bits and SHALL saturate, never wrap.
REQ-022 The stage index SHALL be sized $clog2(NUM_STAGES+1) bits; NUM_STAGES=1 SHALL go directly from the first release to DONE.

Reset
REQ-023 While reset_sync is high on an edge: state=HOLD, reset_out all-ones, seq_done=0, all counters and the stage index cleared.
REQ-024 reset_sync SHALL take priority over lock_in and soft_reset_req on the same edge.
REQ-025 reset_sync asserted mid-STAGE SHALL reassert already-released bits on that edge.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (2-bit localparams) and default parameter values.
REQ-027 One sub-module, sat_down_counter (loadable, saturating at zero, terminal-count flag), SHALL be shared for the hold, filter, and gap counts.
REQ-028 Target size is 120-400 lines of RTL including the sub-module.

Verification (defaults 3/16/4/8)
REQ-029 reset_sync high 5 cycles, then low; lock_in high throughout -> reset_out 111 to 110 at cycle 28, 100 at 36, 000 at 44; seq_done rises at 44.
REQ-030 lock_in toggles low every 3rd cycle in WAIT_LOCK, then held high -> no release until 4 consecutive highs, then bit 0 clears 8 cycles later.
REQ-031 In DONE, lock_in low 1 cycle -> next edge reset_out=111 and seq_done=0; bit 0 clears again 16+4+8 cycles later.
REQ-032 soft_reset_req pulse right after bit 0 clears -> reset_out=111 on the next edge; the full sequence repeats.
REQ-033 reset_sync pulse with soft_reset_req and lock_in low on the same cycle -> reset values only; the sequence restarts from HOLD.
REQ-034 Parameter sweep NUM_STAGES=1, HOLD_CYCLES=1, LOCK_FILTER=1, STAGE_GAP=1 -> bit 0 clears and seq_done rises exactly 3 cycles after reset release.
